student_fir_sched: RTL and testbench

Sample scheduler between the IIS handler and the FIR core. It buffers incoming codec samples in a small FIFO and issues them one at a time to the FIR (start strobe, then wait for done). It scales and saturates the 32-bit FIR result back to the codec sample width and returns it with a one-cycle valid strobe. Also provides FIR bypass, overrun counting and a watchdog timeout for a hung FIR.

---
 rtl/student_fir_sched.sv | 196 +++++++++++++++++++
 tb/tb_student_fir_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/student_fir_sched.sv
// Sample scheduler between the IIS handler and the FIR core: buffers codec samples, runs one
// FIR transaction at a time, then scales and saturates the result back to codec width.
module student_fir_sched #(
    parameter int unsigned DATA_SIZE         = 16,
    parameter int unsigned DATA_SIZE_FIR_OUT = 32,
    parameter int unsigned FIFO_DEPTH        = 4,
    parameter int unsigned SHIFT             = 15,
    parameter int unsigned TIMEOUT_CYCLES    = 4096
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         bypass_i,
    input  logic                         clr_i,
    input  logic [DATA_SIZE-1:0]         in_sample_i,
    input  logic                         in_valid_i,
    output logic [DATA_SIZE-1:0]         fir_sample_o,
    output logic                         fir_start_o,
    input  logic                         fir_done_i,
    input  logic [DATA_SIZE_FIR_OUT-1:0] fir_y_i,
    output logic [DATA_SIZE-1:0]         out_sample_o,
    output logic                         out_valid_o,
    output logic [15:0]                  overrun_cnt_o,
    output logic                         timeout_o,
    output logic                         busy_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES);

    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
    localparam logic [WdW-1:0]  WdLast   = WdW'(TIMEOUT_CYCLES - 1);

    localparam logic signed [DATA_SIZE_FIR_OUT-1:0] SatMax =
        {{(DATA_SIZE_FIR_OUT - DATA_SIZE + 1){1'b0}}, {(DATA_SIZE - 1){1'b1}}};
    localparam logic signed [DATA_SIZE_FIR_OUT-1:0] SatMin =
        {{(DATA_SIZE_FIR_OUT - DATA_SIZE + 1){1'b1}}, {(DATA_SIZE - 1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StOutput,
        StBypassOut
    } state_e;

    state_e state_q, state_d;

    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;

    logic [DATA_SIZE-1:0] fir_sample_q, fir_sample_d, out_sample_q, out_sample_d;
    logic                 fir_start_q, fir_start_d, out_valid_q, out_valid_d;
    logic [WdW-1:0]       wd_q, wd_d;
    logic [15:0]          overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic                 timeout_set;

    logic push_req, push_ok, pop, drop;
    logic [DATA_SIZE-1:0] head;

    logic signed [DATA_SIZE_FIR_OUT-1:0] shifted;
    logic [DATA_SIZE-1:0]                scaled;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_req = in_valid_i & enable_i;
    assign pop      = (state_q == StIdle) & enable_i & (count_q != '0);
    assign push_ok  = push_req & ((count_q != DepthCnt) | pop);
    assign drop     = push_req & ~push_ok;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (!enable_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push_ok && !pop)      count_d = count_q + CntW'(1);
            else if (!push_ok && pop) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= in_sample_i;
    end

    assign shifted = $signed(fir_y_i) >>> SHIFT;

    always_comb begin
        if (shifted > SatMax)      scaled = {1'b0, {(DATA_SIZE - 1){1'b0}}} | SatMax[DATA_SIZE-1:0];
        else if (shifted < SatMin) scaled = SatMin[DATA_SIZE-1:0];
        else                       scaled = shifted[DATA_SIZE-1:0];
    end

    always_comb begin
        state_d      = state_q;
        fir_start_d  = 1'b0;
        fir_sample_d = fir_sample_q;
        out_valid_d  = 1'b0;
        out_sample_d = out_sample_q;
        wd_d         = wd_q;
        timeout_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    if (bypass_i) begin
                        state_d      = StBypassOut;
                        out_valid_d  = 1'b1;
                        out_sample_d = head;
                    end else begin
                        state_d      = StIssue;
                        fir_start_d  = 1'b1;
                        fir_sample_d = head;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
                wd_d    = '0;
            end
            StWait: begin
                if (fir_done_i) begin
                    state_d      = StOutput;
                    out_valid_d  = 1'b1;
                    out_sample_d = scaled;
                end else if (wd_q == WdLast) begin
                    // Hung FIR: emit a zero sample so the codec stream keeps moving.
                    timeout_set  = 1'b1;
                    state_d      = StOutput;
                    out_valid_d  = 1'b1;
                    out_sample_d = '0;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
            end
            StOutput, StBypassOut: state_d = StIdle;
            default:               state_d = StIdle;
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        if (clr_i) begin
            overrun_d = '0;
            timeout_d = 1'b0;
        end else begin
            if (drop && overrun_q != 16'hFFFF) overrun_d = overrun_q + 16'd1;
            if (timeout_set)                   timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fir_sample_q <= '0;
            fir_start_q  <= 1'b0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            wd_q         <= '0;
            overrun_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fir_sample_q <= fir_sample_d;
            fir_start_q  <= fir_start_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            wd_q         <= wd_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign fir_sample_o  = fir_sample_q;
    assign fir_start_o   = fir_start_q;
    assign out_sample_o  = out_sample_q;
    assign out_valid_o   = out_valid_q;
    assign overrun_cnt_o = overrun_q;
    assign timeout_o     = timeout_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_student_fir_sched.sv
// Directed bench for student_fir_sched: stimulus queues expected FIR issues and outputs,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_student_fir_sched;

    localparam int unsigned DW = 16;
    localparam int unsigned FW = 32;

    localparam logic [FW-1:0] SatY [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_8000, 32'hFFFE_0000};
    localparam logic [DW-1:0] SatO [4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFC};

    logic          clk_i       = 1'b0;
    logic          rst_ni      = 1'b0;
    logic          enable_i    = 1'b0;
    logic          bypass_i    = 1'b0;
    logic          clr_i       = 1'b0;
    logic [DW-1:0] in_sample_i = '0;
    logic          in_valid_i  = 1'b0;
    logic          fir_done_i  = 1'b0;
    logic [FW-1:0] fir_y_i     = '0;
    logic [DW-1:0] fir_sample_o;
    logic          fir_start_o;
    logic [DW-1:0] out_sample_o;
    logic          out_valid_o;
    logic [15:0]   overrun_cnt_o;
    logic          timeout_o;
    logic          busy_o;

    student_fir_sched #(
        .DATA_SIZE        (DW),
        .DATA_SIZE_FIR_OUT(FW),
        .FIFO_DEPTH       (4),
        .SHIFT            (15),
        .TIMEOUT_CYCLES   (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .bypass_i     (bypass_i),
        .clr_i        (clr_i),
        .in_sample_i  (in_sample_i),
        .in_valid_i   (in_valid_i),
        .fir_sample_o (fir_sample_o),
        .fir_start_o  (fir_start_o),
        .fir_done_i   (fir_done_i),
        .fir_y_i      (fir_y_i),
        .out_sample_o (out_sample_o),
        .out_valid_o  (out_valid_o),
        .overrun_cnt_o(overrun_cnt_o),
        .timeout_o    (timeout_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_start [$];
    logic [DW-1:0] exp_out   [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (out_valid_o) begin
                if (exp_out.size() == 0) check("out_valid_spurious", 32'(out_valid_o), 32'd0);
                else check("out_sample", 32'(out_sample_o), 32'(exp_out.pop_front()));
            end
            if (fir_start_o) begin
                if (exp_start.size() == 0) check("fir_start_spurious", 32'(fir_start_o), 32'd0);
                else check("fir_sample", 32'(fir_sample_o), 32'(exp_start.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] s);
        in_valid_i  = 1'b1;
        in_sample_i = s;
        tick();
        in_valid_i  = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 40; i++) begin
            if (fir_start_o) return;
            tick();
        end
        check("fir_start_timeout", 32'(fir_start_o), 32'd1);
    endtask

    task automatic pulse_done(input logic [FW-1:0] y);
        fir_done_i = 1'b1;
        fir_y_i    = y;
        tick();
        fir_done_i = 1'b0;
    endtask

    task automatic fir_resp(input int delay, input logic [FW-1:0] y);
        wait_start();
        repeat (delay) tick();
        pulse_done(y);
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_fir_start", 32'(fir_start_o), 32'd0);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_overrun", 32'(overrun_cnt_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        rst_ni   = 1'b1;
        enable_i = 1'b1;
        tick();

        // Single sample with latency checks
        exp_start.push_back(16'h0100);
        exp_out.push_back(16'h0002);
        send(16'h0100);                                   // now cycle 1
        check("t1_busy_c1", 32'(busy_o), 32'd0);
        tick();                                           // cycle 2
        check("t1_start_lat", 32'(fir_start_o), 32'd1);
        check("t1_fir_sample", 32'(fir_sample_o), 32'h0100);
        repeat (5) tick();                                // cycle 7
        pulse_done(32'h0001_0000);                        // cycle 8
        check("t1_out_lat", 32'(out_valid_o), 32'd1);
        check("t1_out_sample", 32'(out_sample_o), 32'h0002);
        tick();
        check("t1_busy_end", 32'(busy_o), 32'd0);

        // Saturation and negative scaling
        for (int i = 0; i < 4; i++) begin
            exp_start.push_back(DW'(16'h0200 + i));
            exp_out.push_back(SatO[i]);
            send(DW'(16'h0200 + i));
            fir_resp(2, SatY[i]);
            repeat (2) tick();
        end

        // Overrun: one issued, four buffered, sixth dropped
        for (int k = 0; k < 5; k++) exp_start.push_back(DW'(16'h0A01 + k));
        for (int k = 0; k < 6; k++) send(DW'(16'h0A01 + k));
        check("t3_overrun", 32'(overrun_cnt_o), 32'd1);
        pulse_clr();
        check("t3_overrun_clr", 32'(overrun_cnt_o), 32'd0);
        check("t3_busy", 32'(busy_o), 32'd1);
        for (int k = 1; k <= 5; k++) exp_out.push_back(DW'(k));
        pulse_done(32'h0000_8000);
        for (int k = 2; k <= 5; k++) fir_resp(1, FW'(k) << 15);
        repeat (3) tick();

        // Watchdog
        exp_start.push_back(16'h0077);
        exp_out.push_back(16'h0000);
        send(16'h0077);
        wait_start();
        repeat (16) tick();
        check("t4_timeout_early", 32'(timeout_o), 32'd0);
        tick();
        check("t4_timeout_set", 32'(timeout_o), 32'd1);
        check("t4_out_valid", 32'(out_valid_o), 32'd1);
        repeat (2) tick();
        pulse_done(32'h0001_0000);
        repeat (3) tick();
        check("t4_timeout_sticky", 32'(timeout_o), 32'd1);
        pulse_clr();
        check("t4_timeout_clr", 32'(timeout_o), 32'd0);

        // Bypass
        bypass_i = 1'b1;
        exp_out.push_back(16'h1234);
        send(16'h1234);
        tick();
        check("t5_out_lat", 32'(out_valid_o), 32'd1);
        check("t5_out_sample", 32'(out_sample_o), 32'h1234);
        tick();
        bypass_i = 1'b0;
        repeat (2) tick();

        // Reset mid-WAIT with two samples queued
        exp_start.push_back(16'h0301);
        send(16'h0301);
        send(16'h0302);
        send(16'h0303);
        tick();
        check("t6_busy_pre", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("t6_busy", 32'(busy_o), 32'd0);
        check("t6_fir_sample", 32'(fir_sample_o), 32'd0);
        check("t6_out_sample", 32'(out_sample_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        pulse_done(32'h0001_0000);
        repeat (8) tick();
        check("t6_busy_post", 32'(busy_o), 32'd0);

        // enable_i low flushes the FIFO; in-flight transaction still completes
        exp_start.push_back(16'h0401);
        exp_out.push_back(16'h0006);
        for (int k = 0; k < 4; k++) send(DW'(16'h0401 + k));
        enable_i = 1'b0;
        tick();
        send(16'h0405);
        pulse_done(32'h0003_0000);
        check("t7_out_valid", 32'(out_valid_o), 32'd1);
        check("t7_overrun", 32'(overrun_cnt_o), 32'd0);
        enable_i = 1'b1;
        repeat (10) tick();
        check("t7_busy", 32'(busy_o), 32'd0);

        check("exp_out_left", 32'(exp_out.size()), 32'd0);
        check("exp_start_left", 32'(exp_start.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
